proj_to_affine: RTL
===================

Name: proj_to_affine

Overview:
- Downstream of the extended-coordinate point adder/doubler.
- Takes a projective result (X, Y, Z) and returns affine x = X·Z⁻¹, y = Y·Z⁻¹ over p = 2^255−19.
- Z⁻¹ is computed as Z^(p−2) by right-to-left square-and-multiply, using two numberMul instances in parallel.
- Feeds the encoder/compare stage at the end of scalar multiplication.

Parameters:
- WIDTH, 255, field element width. Only 255 is supported.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  start request; sampled only in S_IDLE
- i_x  in  255  projective X (numberMul domain)
- i_y  in  255  projective Y
- i_z  in  255  projective Z
- o_x  out  255  affine x; held until next completion
- o_y  out  255  affine y; held until next completion
- o_busy  out  1  high whenever state ≠ S_IDLE
- o_valid  out  1  one-cycle pulse when o_x/o_y update
- o_error  out  1  ZERO_CHECK_EN only: Z==0 flag, valid with o_valid

Behaviour:
- Reset: state S_IDLE; o_x, o_y, o_valid, o_busy, o_error = 0; counter = 0. numberMul instances share i_rst.
- Reset mid-operation aborts immediately. The in-flight multiplier result is discarded and no o_valid is produced.
- mul(a,b) denotes the numberMul product. Both instances get one shared start pulse; completion is taken from mul0 finished only.
- k = cycles from the numberMul start-pulse cycle to its finished cycle.
- Exponent E = p−2 = 2^255−21, constant in the package. All 255 bits are 1 except bits 2 and 4.
- Registers: acc, base, xs, ys (255b each); round counter i (8b).

States:
- S_IDLE: if i_start, capture xs=i_x, ys=i_y, base=i_z, acc=i_z (bit 0 consumed), i=0 → S_EXP_ISSUE. i_start in any other state is ignored, with no queueing.
- S_EXP_ISSUE: pulse start with mul0 = mul(base,base) and mul1 = mul(acc,base) → S_EXP_WAIT.
- S_EXP_WAIT: on finished:
  - base ← mul0.
  - acc ← mul1 only if E[i]==1 and i≠0.
  - If i==254 → S_FIN_ISSUE; else i++ → S_EXP_ISSUE.
- S_FIN_ISSUE: pulse start with mul0 = mul(xs,acc) and mul1 = mul(ys,acc) → S_FIN_WAIT.
- S_FIN_WAIT: on finished, o_x←mul0, o_y←mul1 → S_DONE.
- S_DONE: o_valid=1 for this cycle only → S_IDLE.

Latency:
- With i_start sampled at cycle 0, o_valid is high at cycle 256·(k+1)+1.
- 255 exponent rounds + 1 final round, each k+1 cycles, plus the S_DONE cycle.
- A new i_start is accepted in the cycle after o_valid.

Arithmetic:
- All operands and results are 255b. No reduction is performed here; numberMul outputs are already reduced.
- Z==0 yields acc=0, so outputs are 0 naturally.

Optional Feature:
- Macro: PROJ_TO_AFFINE_ZERO_CHECK_EN.
- Defined:
  - In S_IDLE with i_start and i_z==0: go directly to S_DONE with o_x=o_y=0 and o_error=1. o_valid occurs at cycle 1.
  - o_error is cleared at the next accepted start.
  - For nonzero Z, o_error=0 with the normal latency.
- Undefined:
  - o_error is tied 0.
  - Z==0 takes full latency and returns x=y=0.

Decomposition:
- Shared package (ed25519_pkg):
  - state_t enum (S_IDLE, S_EXP_ISSUE, S_EXP_WAIT, S_FIN_ISSUE, S_FIN_WAIT, S_DONE).
  - P (2^255−19).
  - P_MINUS_2 exponent constant.
  - EXP_BITS=255.
- Reuse existing numberMul ×2. No new sub-module; the control FSM and registers live in this block.

Test Plan:
- Z=1, X=5, Y=7: o_x==mul(5,R1), o_y==mul(7,R1), where R1 = software-model Z^(p−2) built from the bit-exact numberMul model. o_valid pulses exactly once, at cycle 256(k+1)+1.
- Random Z (e.g. 0x1234…ABCD), X, Y, 20 vectors: outputs match software model; o_busy high from cycle 1 through the S_DONE cycle; o_valid width is 1 cycle.
- Z=0, X=Y=9:
  - Feature off: o_x=o_y=0 after full latency, o_error=0.
  - Feature on: o_valid at cycle 1 with o_x=o_y=0, o_error=1.
- i_start re-asserted at cycles 10 and 500 during an operation: ignored; a single o_valid with the first operand set's result.
- i_rst asserted at cycle 300: next cycle o_busy=0 and outputs 0; no o_valid. A fresh start afterwards completes correctly.
- Back-to-back: second i_start in the cycle after o_valid is accepted. o_x/o_y hold the first result until the second o_valid.

Source files
------------

// File: rtl/ed25519_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ed25519_pkg
// Description : Shared definitions for the Ed25519 field-arithmetic slice:
//               projective-to-affine FSM states, the field prime P and the
//               inversion exponent P-2 used by Fermat inversion.
// Revision    : 1.0 - initial release
// ============================================================================
package ed25519_pkg;

    // Number of exponent bits walked by the inversion loop
    localparam int EXP_BITS = 255;

    // p = 2^255 - 19
    localparam logic [254:0] P =
        255'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;

    // p - 2 = 2^255 - 21 : every bit set except bits 2 and 4
    localparam logic [254:0] P_MINUS_2 =
        255'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffeb;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_EXP_ISSUE = 3'd1,
        S_EXP_WAIT  = 3'd2,
        S_FIN_ISSUE = 3'd3,
        S_FIN_WAIT  = 3'd4,
        S_DONE      = 3'd5
    } state_t;

endpackage : ed25519_pkg
`default_nettype wire

// File: rtl/numberMul.sv
`default_nettype none
// ============================================================================
// Module      : numberMul
// Description : Pipelined modular multiplier over p = 2^255 - 19.
//               o_result = i_a * i_b mod p, fully reduced (< p).
//               o_finished pulses exactly 3 cycles after the i_start cycle.
// Ports       : i_clk, i_rst       clock / synchronous active-high reset
//               i_start            capture operands this cycle
//               i_a, i_b [254:0]   operands
//               o_result [254:0]   reduced product, held until next finish
//               o_finished         one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module numberMul
    import ed25519_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [254:0] i_a,
    input  logic [254:0] i_b,
    output logic [254:0] o_result,
    output logic         o_finished
);

    logic [254:0] r_a;
    logic [254:0] r_b;
    logic         r_v1;
    logic [259:0] r_t;
    logic         r_v2;
    logic [254:0] r_result;
    logic         r_finished;

    logic [509:0] w_prod;
    logic [259:0] w_fold1;
    logic [255:0] w_fold2;
    logic [255:0] w_sub;
    logic [254:0] w_red;

    // 2^255 == 19 (mod p): fold the high half down twice, then one
    // conditional subtraction brings the value below p.
    assign w_prod  = {255'd0, r_a} * {255'd0, r_b};
    assign w_fold1 = {5'd0, w_prod[254:0]} + ({5'd0, w_prod[509:255]} * 260'd19);
    // After the first fold the high part is below 20, so this sum is < 2p
    assign w_fold2 = {1'b0, r_t[254:0]} + ({251'd0, r_t[259:255]} * 256'd19);
    assign w_sub   = w_fold2 - {1'b0, P};
    // A borrow out of the subtraction means the value was already below p
    assign w_red   = w_sub[255] ? w_fold2[254:0] : w_sub[254:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_v1       <= 1'b0;
            r_t        <= '0;
            r_v2       <= 1'b0;
            r_result   <= '0;
            r_finished <= 1'b0;
        end else begin
            if (i_start) begin
                r_a <= i_a;
                r_b <= i_b;
            end
            r_v1       <= i_start;
            r_t        <= w_fold1;
            r_v2       <= r_v1;
            r_finished <= r_v2;
            if (r_v2) begin
                r_result <= w_red;
            end
        end
    end

    assign o_result   = r_result;
    assign o_finished = r_finished;

endmodule : numberMul
`default_nettype wire

// File: rtl/proj_to_affine.sv
`default_nettype none
// ============================================================================
// Module      : proj_to_affine
// Description : Converts a projective point (X, Y, Z) to affine
//               x = X/Z, y = Y/Z over p = 2^255 - 19. Z^-1 = Z^(p-2) is
//               computed by right-to-left square-and-multiply on two
//               numberMul instances sharing one start pulse.
// Ports       : i_clk, i_rst        clock / synchronous active-high reset
//               i_start             start request, sampled only when idle
//               i_x, i_y, i_z       projective coordinates
//               o_x, o_y            affine result, held until next completion
//               o_busy              high whenever not idle
//               o_valid             one-cycle pulse when o_x/o_y update
//               o_error             Z==0 flag (zero-check build only)
// Options     : PROJ_TO_AFFINE_ZERO_CHECK_EN - short-circuit Z==0 to an
//               immediate zero result with o_error set.
// Revision    : 1.0 - initial release
// ============================================================================
module proj_to_affine
    import ed25519_pkg::*;
#(
    parameter int WIDTH = 255   // only 255 is supported
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic [WIDTH-1:0] i_z,
    output logic [WIDTH-1:0] o_x,
    output logic [WIDTH-1:0] o_y,
    output logic             o_busy,
    output logic             o_valid,
    output logic             o_error
);

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_base;
    logic [WIDTH-1:0] r_xs;
    logic [WIDTH-1:0] r_ys;
    logic [7:0]       r_i;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic             r_valid;

    logic             w_mul_start;
    logic [WIDTH-1:0] w_mul0_a;
    logic [WIDTH-1:0] w_mul0_b;
    logic [WIDTH-1:0] w_mul1_a;
    logic [WIDTH-1:0] w_mul1_b;
    logic [WIDTH-1:0] w_mul0_res;
    logic [WIDTH-1:0] w_mul1_res;
    logic             w_mul0_done;
    logic             w_mul1_done_unused;

    // Both multipliers run in lockstep; mul0 alone signals completion.
    assign w_mul_start = (r_state == S_EXP_ISSUE) || (r_state == S_FIN_ISSUE);

    always_comb begin
        // Exponent round: square the base, multiply accumulator by base
        w_mul0_a = r_base;
        w_mul0_b = r_base;
        w_mul1_a = r_acc;
        w_mul1_b = r_base;
        if (r_state == S_FIN_ISSUE) begin
            // Final round: scale both coordinates by Z^-1
            w_mul0_a = r_xs;
            w_mul0_b = r_acc;
            w_mul1_a = r_ys;
            w_mul1_b = r_acc;
        end
    end

    numberMul u_mul0 (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (w_mul_start),
        .i_a        (w_mul0_a),
        .i_b        (w_mul0_b),
        .o_result   (w_mul0_res),
        .o_finished (w_mul0_done)
    );

    numberMul u_mul1 (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (w_mul_start),
        .i_a        (w_mul1_a),
        .i_b        (w_mul1_b),
        .o_result   (w_mul1_res),
        .o_finished (w_mul1_done_unused)
    );

`ifdef PROJ_TO_AFFINE_ZERO_CHECK_EN
    logic r_error;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_base  <= '0;
            r_xs    <= '0;
            r_ys    <= '0;
            r_i     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_valid <= 1'b0;
`ifdef PROJ_TO_AFFINE_ZERO_CHECK_EN
            r_error <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_xs   <= i_x;
                        r_ys   <= i_y;
                        r_base <= i_z;
                        // Exponent bit 0 is 1, so the accumulator starts at Z
                        r_acc  <= i_z;
                        r_i    <= 8'd0;
`ifdef PROJ_TO_AFFINE_ZERO_CHECK_EN
                        if (i_z == '0) begin
                            r_x     <= '0;
                            r_y     <= '0;
                            r_error <= 1'b1;
                            r_valid <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_error <= 1'b0;
                            r_state <= S_EXP_ISSUE;
                        end
`else
                        r_state <= S_EXP_ISSUE;
`endif
                    end
                end

                S_EXP_ISSUE: begin
                    r_state <= S_EXP_WAIT;
                end

                S_EXP_WAIT: begin
                    if (w_mul0_done) begin
                        r_base <= w_mul0_res;
                        // Round 0 only squares: bit 0 was folded in at start
                        if (P_MINUS_2[r_i] && (r_i != 8'd0)) begin
                            r_acc <= w_mul1_res;
                        end
                        if (r_i == 8'(EXP_BITS - 1)) begin
                            r_state <= S_FIN_ISSUE;
                        end else begin
                            r_i     <= r_i + 8'd1;
                            r_state <= S_EXP_ISSUE;
                        end
                    end
                end

                S_FIN_ISSUE: begin
                    r_state <= S_FIN_WAIT;
                end

                S_FIN_WAIT: begin
                    if (w_mul0_done) begin
                        r_x     <= w_mul0_res;
                        r_y     <= w_mul1_res;
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_valid = r_valid;
    assign o_busy  = (r_state != S_IDLE);

`ifdef PROJ_TO_AFFINE_ZERO_CHECK_EN
    assign o_error = r_error;
`else
    assign o_error = 1'b0;
`endif

endmodule : proj_to_affine
`default_nettype wire
